// File: rtl/parity_frame_checker_if.sv
// Link bundle between the serial bit source (master) and the parity frame checker (slave).
// Each frame is a start strobe, then DATA_W data bits LSB first, then one parity bit.
interface parity_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] data_out;
  logic              parity_err;
  logic              out_valid;
  logic              out_ready;

  // Handshake: a result transfers on the rising edge where out_valid && out_ready.
  // Once out_valid rises, data_out/parity_err stay frozen until that transfer,
  // and out_valid does not depend combinationally on out_ready.
  modport master (
    output start, bit_in, bit_valid, out_ready,
    input  data_out, parity_err, out_valid
  );

  modport slave (
    input  start, bit_in, bit_valid, out_ready,
    output data_out, parity_err, out_valid
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial parity frame receiver: deserialises DATA_W bits plus parity and reports word + error flag.
// Optional macro PARITY_ERR_CNT_EN adds a saturating 8-bit err_count of accepted bad frames.
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  parity_frame_checker_if.slave  link,
  output logic                   busy,
  output logic                   overrun,
  output logic [1:0]             state
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]             err_count
`endif
);
  localparam int   CNT_W = $clog2(DATA_W + 1);
  localparam logic ODD   = (ODD_PARITY != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, HOLD = 2'd3} state_t;

  state_t            st;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  count;
  logic              acc;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              valid_q;

  assign link.data_out   = data_q;
  assign link.parity_err = err_q;
  assign link.out_valid  = valid_q;
  assign state           = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      shreg   <= '0;
      count   <= '0;
      acc     <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
      err_count <= 8'd0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (link.start) begin
            st    <= DATA;
            count <= '0;
            acc   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        DATA: begin
          if (link.start) begin
            count <= '0;
            acc   <= 1'b0;
          end else if (link.bit_valid) begin
            // Right shift lands the first (LSB) bit at position 0 after DATA_W bits.
            shreg <= {link.bit_in, shreg[DATA_W-1:1]};
            acc   <= acc ^ link.bit_in;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(DATA_W - 1)) st <= PARITY;
          end
        end
        PARITY: begin
          if (link.start) begin
            st    <= DATA;
            count <= '0;
            acc   <= 1'b0;
          end else if (link.bit_valid) begin
            data_q  <= shreg;
            err_q   <= ((acc ^ link.bit_in) != ODD);
            valid_q <= 1'b1;
            busy    <= 1'b0;
            st      <= HOLD;
          end
        end
        HOLD: begin
          if (link.start) overrun <= 1'b1;
          if (valid_q && link.out_ready) begin
            valid_q <= 1'b0;
            st      <= IDLE;
`ifdef PARITY_ERR_CNT_EN
            if (err_q && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
`endif
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
